// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter and instruction-fetch sequencer. Issues a request to the
//   instruction ROM and waits for its acknowledge, which may arrive in the
//   same cycle as the request. It then holds the fetched word for the execute
//   stage and selects the next PC from the execute-stage results. The
//   instruction counter is also kept here.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; moves to FETCH on the next clock
//   FETCH | irom_req_o high, irom_addr_o = PC; waits for irom_ack_i
//   EXEC  | inst_o/current_pc_o valid; leaves when stall_i is low
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   npc_op_i              next-PC select (00 +4, 01 branch, 10 JAL, 11 JALR)
//   ext_i                 sign-extended immediate
//   alu_result_i          ALU result (JALR target)
//   alu_branch_i          branch-taken flag
//   stall_i               hold the current instruction in EXEC
//   irom_req_o/addr_o     fetch request and address
//   irom_ack_i/inst_i     fetch acknowledge and fetched word
//   current_pc_o, pc4_o   PC of the current instruction and PC+4
//   inst_o, inst_valid_o  latched instruction and its valid flag
//   trap_o                one-cycle pulse after a misaligned target
//   instret_o             retired instruction count
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_001C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  npc_op_i,
  input  logic [31:0] ext_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_branch_i,
  input  logic        stall_i,
  output logic        irom_req_o,
  output logic [31:0] irom_addr_o,
  input  logic        irom_ack_i,
  input  logic [31:0] irom_inst_i,
  output logic [31:0] current_pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        trap_o,
  output logic [31:0] instret_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] instret;
  logic        trap;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_ext;
  logic [31:0] target;

  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_ext = pc + ext_i;

  // All additions wrap modulo 2^32; JALR drops bit 0 before the alignment check.
  always_comb begin
    target = pc_plus4;
    case (npc_op_i)
      2'b01:   target = alu_branch_i ? pc_plus_ext : pc_plus4;
      2'b10:   target = pc_plus_ext;
      2'b11:   target = alu_result_i & ~32'h1;
      default: target = pc_plus4;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      inst    <= 32'h0;
      instret <= 32'h0;
      trap    <= 1'b0;
    end else begin
      trap <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (irom_ack_i) begin
            inst  <= irom_inst_i;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall_i) begin
            instret <= instret + 32'd1;
            state   <= FETCH;
            // A misaligned target still retires the instruction; fetch resumes at the trap vector.
            if (target[1:0] != 2'b00) begin
              pc   <= TRAP_PC;
              trap <= 1'b1;
            end else begin
              pc <= target;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request and valid decode straight from the state register, so an
  // asynchronous reset drops them without waiting for a clock.
  assign irom_req_o   = (state == FETCH);
  assign inst_valid_o = (state == EXEC);
  assign irom_addr_o  = pc;
  assign current_pc_o = pc;
  assign pc4_o        = pc_plus4;
  assign inst_o       = inst;
  assign trap_o       = trap;
  assign instret_o    = instret;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  npc_op_i = 2'b00;
  logic [31:0] ext_i = 32'h0;
  logic [31:0] alu_result_i = 32'h0;
  logic        alu_branch_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        irom_req_o;
  logic [31:0] irom_addr_o;
  logic        irom_ack_i = 1'b0;
  logic [31:0] irom_inst_i = 32'h0;
  logic [31:0] current_pc_o;
  logic [31:0] pc4_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        trap_o;
  logic [31:0] instret_o;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_instret = 32'h0;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .TRAP_PC(32'h0000_001C)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .npc_op_i(npc_op_i), .ext_i(ext_i),
    .alu_result_i(alu_result_i), .alu_branch_i(alu_branch_i), .stall_i(stall_i),
    .irom_req_o(irom_req_o), .irom_addr_o(irom_addr_o), .irom_ack_i(irom_ack_i),
    .irom_inst_i(irom_inst_i), .current_pc_o(current_pc_o), .pc4_o(pc4_o),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .trap_o(trap_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  // Called at a falling edge while in FETCH: acknowledge immediately.
  task automatic fetch_now(input logic [31:0] word);
    irom_ack_i  = 1'b1;
    irom_inst_i = word;
    step();
    irom_ack_i  = 1'b0;
    irom_inst_i = 32'hFFFF_FFFF;
  endtask

  // Called at a falling edge while in EXEC: leave EXEC with the given next-PC inputs.
  task automatic exec_go(input logic [1:0] op, input logic [31:0] ext,
                         input logic [31:0] alu, input logic br);
    npc_op_i = op; ext_i = ext; alu_result_i = alu; alu_branch_i = br; stall_i = 1'b0;
    step();
    exp_instret = exp_instret + 32'd1;
    npc_op_i = 2'b00; ext_i = 32'h0; alu_result_i = 32'h0; alu_branch_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (irom_req_o !== 1'b0) begin failed++; $display("FAIL reset_req: got %b expected 0", irom_req_o); end
    tests++; if (inst_valid_o !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    tests++; if (current_pc_o !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h expected 00000000", current_pc_o); end
    tests++; if (pc4_o !== 32'h4) begin failed++; $display("FAIL reset_pc4: got %h expected 00000004", pc4_o); end
    tests++; if ({inst_o, instret_o} !== 64'h0) begin failed++; $display("FAIL reset_inst_instret: got %h/%h expected 0/0", inst_o, instret_o); end
    tests++; if (trap_o !== 1'b0) begin failed++; $display("FAIL reset_trap: got %b expected 0", trap_o); end
    irom_ack_i = 1'b1;
    step(); step();
    tests++; if (irom_req_o !== 1'b0 || inst_o !== 32'h0) begin failed++; $display("FAIL reset_held: req %b inst %h expected 0/0", irom_req_o, inst_o); end
    irom_ack_i = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    rst_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      w = 32'hA000_0000 + 32'(i);
      tests++; if (irom_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin failed++; $display("FAIL seq_fetch_state[%0d]: req %b valid %b expected 1/0", i, irom_req_o, inst_valid_o); end
      tests++; if (irom_addr_o !== 32'(4 * i)) begin failed++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, irom_addr_o, 32'(4 * i)); end
      fetch_now(w);
      tests++; if (inst_valid_o !== 1'b1 || irom_req_o !== 1'b0) begin failed++; $display("FAIL seq_exec_state[%0d]: valid %b req %b expected 1/0", i, inst_valid_o, irom_req_o); end
      tests++; if (inst_o !== w) begin failed++; $display("FAIL seq_inst[%0d]: got %h expected %h", i, inst_o, w); end
      tests++; if (pc4_o !== 32'(4 * i + 4)) begin failed++; $display("FAIL seq_pc4[%0d]: got %h expected %h", i, pc4_o, 32'(4 * i + 4)); end
      exec_go(2'b00, 32'h0, 32'h0, 1'b0);
    end
    tests++; if (instret_o !== 32'd3) begin failed++; $display("FAIL seq_instret: got %0d expected 3", instret_o); end
    tests++; if (inst_valid_o !== 1'b0 || irom_addr_o !== 32'hC) begin failed++; $display("FAIL seq_next: valid %b addr %h expected 0/0000000c", inst_valid_o, irom_addr_o); end
  endtask

  task automatic test_ack_delay();
    int req_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      if (irom_req_o === 1'b1) req_cycles++;
      tests++; if (irom_addr_o !== 32'hC) begin failed++; $display("FAIL delay_addr[%0d]: got %h expected 0000000c", k, irom_addr_o); end
      irom_ack_i  = (k == 3);
      irom_inst_i = (k == 3) ? 32'h1234_5678 : (32'hBAD0_0000 + 32'(k));
      step();
    end
    irom_ack_i = 1'b0;
    tests++; if (req_cycles != 4) begin failed++; $display("FAIL delay_req_cycles: got %0d expected 4", req_cycles); end
    tests++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h1234_5678) begin failed++; $display("FAIL delay_inst: valid %b inst %h expected 1/12345678", inst_valid_o, inst_o); end
    exec_go(2'b00, 32'h0, 32'h0, 1'b0);
    tests++; if (irom_addr_o !== 32'h10 || instret_o !== exp_instret) begin failed++; $display("FAIL delay_next: addr %h instret %0d expected 00000010/%0d", irom_addr_o, instret_o, exp_instret); end
  endtask

  task automatic test_branch_trap();
    fetch_now(32'h0000_006F);
    exec_go(2'b10, 32'h0000_00F0, 32'h0, 1'b0);
    tests++; if (irom_addr_o !== 32'h100) begin failed++; $display("FAIL jal_addr: got %h expected 00000100", irom_addr_o); end
    fetch_now(32'h0000_0063);
    exec_go(2'b01, 32'hFFFF_FFF0, 32'h0, 1'b1);
    tests++; if (irom_addr_o !== 32'hF0 || trap_o !== 1'b0) begin failed++; $display("FAIL br_taken: addr %h trap %b expected 000000f0/0", irom_addr_o, trap_o); end
    fetch_now(32'h0000_006F);
    exec_go(2'b10, 32'h0000_0010, 32'h0, 1'b0);
    fetch_now(32'h0000_0063);
    exec_go(2'b01, 32'hFFFF_FFF0, 32'h0, 1'b0);
    tests++; if (irom_addr_o !== 32'h104) begin failed++; $display("FAIL br_not_taken: got %h expected 00000104", irom_addr_o); end
    fetch_now(32'h0000_0067);
    exec_go(2'b11, 32'h0, 32'h0000_0301, 1'b0);
    tests++; if (irom_addr_o !== 32'h300 || trap_o !== 1'b0) begin failed++; $display("FAIL jalr_aligned: addr %h trap %b expected 00000300/0", irom_addr_o, trap_o); end
    fetch_now(32'h0000_0067);
    exec_go(2'b11, 32'h0, 32'h0000_0203, 1'b0);
    tests++; if (irom_addr_o !== 32'h1C || trap_o !== 1'b1) begin failed++; $display("FAIL jalr_trap: addr %h trap %b expected 0000001c/1", irom_addr_o, trap_o); end
    tests++; if (instret_o !== exp_instret) begin failed++; $display("FAIL trap_instret: got %0d expected %0d", instret_o, exp_instret); end
    step();
    tests++; if (trap_o !== 1'b0 || irom_req_o !== 1'b1) begin failed++; $display("FAIL trap_pulse: trap %b req %b expected 0/1", trap_o, irom_req_o); end
  endtask

  task automatic test_stall();
    int valid_cycles = 0;
    logic [31:0] pc_hold;
    fetch_now(32'h5555_AAAA);
    pc_hold = current_pc_o;
    stall_i = 1'b1; npc_op_i = 2'b10; ext_i = 32'h40;
    irom_ack_i = 1'b1; irom_inst_i = 32'hDEAD_0001;
    for (int k = 0; k < 6; k++) begin
      if (inst_valid_o === 1'b1) valid_cycles++;
      if (k == 5) begin
        stall_i = 1'b0; npc_op_i = 2'b00; ext_i = 32'h0; irom_ack_i = 1'b0;
      end
      step();
      if (k < 4) begin
        tests++; if (current_pc_o !== pc_hold || instret_o !== exp_instret || inst_o !== 32'h5555_AAAA) begin
          failed++; $display("FAIL stall_hold[%0d]: pc %h instret %0d inst %h expected %h/%0d/5555aaaa", k, current_pc_o, instret_o, inst_o, pc_hold, exp_instret);
        end
      end
    end
    exp_instret = exp_instret + 32'd1;
    tests++; if (valid_cycles != 6) begin failed++; $display("FAIL stall_valid_cycles: got %0d expected 6", valid_cycles); end
    tests++; if (current_pc_o !== pc_hold + 32'd4 || instret_o !== exp_instret) begin failed++; $display("FAIL stall_release: pc %h instret %0d expected %h/%0d", current_pc_o, instret_o, pc_hold + 32'd4, exp_instret); end
  endtask

  task automatic test_wrap_and_reset();
    fetch_now(32'h0000_0067);
    exec_go(2'b11, 32'h0, 32'hFFFF_FFFC, 1'b0);
    tests++; if (irom_addr_o !== 32'hFFFF_FFFC || pc4_o !== 32'h0) begin failed++; $display("FAIL wrap_setup: addr %h pc4 %h expected fffffffc/00000000", irom_addr_o, pc4_o); end
    fetch_now(32'h0000_0013);
    exec_go(2'b00, 32'h0, 32'h0, 1'b0);
    tests++; if (irom_addr_o !== 32'h0 || trap_o !== 1'b0) begin failed++; $display("FAIL wrap_addr: addr %h trap %b expected 00000000/0", irom_addr_o, trap_o); end
    fetch_now(32'h0000_0013);
    exec_go(2'b00, 32'h0, 32'h0, 1'b0);
    tests++; if (irom_req_o !== 1'b1 || irom_addr_o !== 32'h4) begin failed++; $display("FAIL pre_reset_fetch: req %b addr %h expected 1/00000004", irom_req_o, irom_addr_o); end
    #2 rst_i = 1'b1;
    #1;
    tests++; if (irom_req_o !== 1'b0 || current_pc_o !== 32'h0 || instret_o !== 32'h0) begin failed++; $display("FAIL async_reset: req %b pc %h instret %0d expected 0/00000000/0", irom_req_o, current_pc_o, instret_o); end
    step();
    rst_i = 1'b0;
    irom_ack_i = 1'b1; irom_inst_i = 32'hDEAD_BEEF;
    step();
    irom_ack_i = 1'b0;
    exp_instret = 32'h0;
    tests++; if (irom_req_o !== 1'b1 || inst_valid_o !== 1'b0 || irom_addr_o !== 32'h0) begin failed++; $display("FAIL late_ack_ignored: req %b valid %b addr %h expected 1/0/00000000", irom_req_o, inst_valid_o, irom_addr_o); end
    tests++; if (inst_o !== 32'h0) begin failed++; $display("FAIL late_ack_inst: got %h expected 00000000", inst_o); end
    fetch_now(32'h0000_1111);
    tests++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_1111) begin failed++; $display("FAIL restart_fetch: valid %b inst %h expected 1/00001111", inst_valid_o, inst_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_branch_trap();
    test_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter TRAP_PC, 32'h0000_001C, PC loaded on misaligned-target trap.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 npc_op_i  input  2  next-PC select: 00 PC+4, 01 branch (PC+ext_i if alu_branch_i else PC+4), 10 JAL (PC+ext_i), 11 JALR (alu_result_i with bit0 cleared).
REQ-006 ext_i  input  32  sign-extended immediate from decode.
REQ-007 alu_result_i  input  32  execute-stage ALU result.
REQ-008 alu_branch_i  input  1  execute-stage branch-taken flag.
REQ-009 stall_i  input  1  hold current instruction in EXEC.
REQ-010 irom_req_o  output  1  instruction fetch request.
REQ-011 irom_addr_o  output  32  fetch address, equals current_pc_o.
REQ-012 irom_ack_i  input  1  fetch complete; irom_inst_i valid this cycle.
REQ-013 irom_inst_i  input  32  fetched instruction word.
REQ-014 current_pc_o  output  32  PC of instruction being fetched/executed (feeds execute).
REQ-015 pc4_o  output  32  current_pc_o + 4 (link value for writeback).
REQ-016 inst_o  output  32  latched instruction.
REQ-017 inst_valid_o  output  1  high while in EXEC; inst_o and current_pc_o valid for execute.
REQ-018 trap_o  output  1  one-cycle pulse on misaligned target.
REQ-019 instret_o  output  32  count of completed instructions.

Function
REQ-020 FSM states IDLE, FETCH, EXEC; reset enters IDLE; IDLE -> FETCH unconditionally next cycle.
REQ-021 FETCH: irom_req_o=1, irom_addr_o=PC stable; stays FETCH until irom_ack_i; on ack latch irom_inst_i into inst_o, go EXEC.
REQ-022 Ack in the same cycle req first rises is legal: minimum FETCH duration one cycle.
REQ-023 irom_ack_i in IDLE or EXEC is ignored; irom_req_o=0 outside FETCH.
REQ-024 EXEC: inst_valid_o=1; if stall_i=1 stay EXEC, PC/inst_o/instret_o unchanged.
REQ-025 EXEC with stall_i=0: compute target per REQ-005, PC <= target, instret_o += 1, go FETCH.
REQ-026 Target arithmetic modulo 2^32: PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag; instret_o wraps likewise.
REQ-027 Target with bits[1:0] != 00 (after JALR bit0 clear): PC <= TRAP_PC, trap_o=1 for exactly the next cycle, instruction still counted.
REQ-028 npc_op_i, ext_i, alu_result_i, alu_branch_i sampled only in the EXEC cycle that leaves EXEC.
REQ-029 pc4_o combinational from current_pc_o; inst_valid_o and irom_req_o decoded from state only.

Reset
REQ-030 rst_i asserted: state=IDLE, PC=RESET_PC, inst_o=0, instret_o=0, trap_o=0, irom_req_o=0, inst_valid_o=0, immediately regardless of clock.
REQ-031 Reset mid-FETCH drops irom_req_o asynchronously; a late ack after release (in IDLE) is ignored and fetch restarts at RESET_PC.

Verification
REQ-032 Reset release, ack 0-cycle delay, op=00: addresses 0x0,0x4,0x8 fetched; each EXEC one cycle; instret_o=3 after third EXEC.
REQ-033 FETCH with ack delayed 3 cycles: irom_req_o high 4 cycles, addr constant, inst_o = ack-cycle irom_inst_i.
REQ-034 PC=0x100, op=01, ext_i=0xFFFFFFF0, alu_branch_i=1 -> next addr 0xF0; alu_branch_i=0 -> 0x104; op=11, alu_result_i=0x203 -> 0x202 misaligned -> addr TRAP_PC, trap_o one cycle.
REQ-035 stall_i high 5 cycles in EXEC: inst_valid_o high 6 cycles, PC/instret_o unchanged until stall drops, then one increment.
REQ-036 PC=0xFFFFFFFC, op=00 -> next addr 0x0; rst_i pulsed mid-FETCH with ack arriving after release -> ack ignored, first fetch at RESET_PC.
